// File: rtl/ram_rw_ctrl_pkg.sv
// rtl/ram_rw_ctrl_pkg.sv - shared types, constants and pattern function for the RAM self-test sequencer
package ram_rw_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_TURN  = 3'd2,
        S_READ  = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    localparam int TURN_CYCLES = 1;

    // Callers truncate the result to their data width.
    function automatic logic [31:0] pattern(input logic [31:0] addr, input logic [31:0] base);
        return addr + base;
    endfunction

endpackage

// File: rtl/ram_rw_ctrl_if.sv
// rtl/ram_rw_ctrl_if.sv - two-port RAM bus between the self-test sequencer and the RAM
interface ram_rw_ctrl_if #(
    parameter int AW = 6,
    parameter int DW = 8
) ();
    logic          ram_wr_en;
    logic          ram_wr_we;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic          ram_rd_en;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;

    modport master (
        output ram_wr_en, ram_wr_we, ram_wr_addr, ram_wr_data,
        output ram_rd_en, ram_rd_addr,
        input  ram_rd_data
    );

    modport slave (
        input  ram_wr_en, ram_wr_we, ram_wr_addr, ram_wr_data,
        input  ram_rd_en, ram_rd_addr,
        output ram_rd_data
    );
endinterface

// File: rtl/ram_rw_ctrl_rd_checker.sv
// rtl/ram_rw_ctrl_rd_checker.sv - read-latency aligned comparator with sticky error and mismatch count
module ram_rd_checker
    import ram_rw_pkg::*;
#(
    parameter int          AW        = 6,
    parameter int          DW        = 8,
    parameter int unsigned DATA_BASE = 'h10,
    parameter int          RD_LAT    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          err,
    output logic [AW:0]   err_cnt
);

    logic [RD_LAT-1:0]         vld_q, vld_d;
    logic [RD_LAT-1:0][DW-1:0] exp_q, exp_d;
    logic                      err_q, err_d;
    logic [AW:0]               err_cnt_q, err_cnt_d;
    logic                      mismatch;

    always_comb begin
        vld_d     = vld_q;
        exp_d     = exp_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        mismatch  = vld_q[RD_LAT-1] && (rd_data != exp_q[RD_LAT-1]);

        // Stage RD_LAT-1 lines up with the data the RAM returns this cycle.
        for (int i = RD_LAT - 1; i > 0; i--) begin
            vld_d[i] = vld_q[i-1];
            exp_d[i] = exp_q[i-1];
        end
        vld_d[0] = rd_en;
        exp_d[0] = DW'(pattern(32'(rd_addr), 32'(DATA_BASE)));

        if (clear) begin
            vld_d     = '0;
            err_d     = 1'b0;
            err_cnt_d = '0;
        end else if (mismatch) begin
            err_d     = 1'b1;
            err_cnt_d = err_cnt_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= '0;
            exp_q     <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            vld_q     <= vld_d;
            exp_q     <= exp_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: rtl/ram_rw_ctrl.sv
// rtl/ram_rw_ctrl.sv - write-then-read-back self-test sequencer for a two-port RAM
module ram_rw_ctrl
    import ram_rw_pkg::*;
#(
    parameter int          AW        = 6,
    parameter int          DEPTH     = 64,
    parameter int          DW        = 8,
    parameter int unsigned DATA_BASE = 'h10,
    parameter int          RD_LAT    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   err_cnt,
    ram_rw_ctrl_if.master ram
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          wr_en_q, wr_en_d;
    logic          rd_en_q, rd_en_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [1:0]    wait_cnt_q, wait_cnt_d;
    logic          accept;

    assign accept = (state_q == S_IDLE) && start;

    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        wr_en_d    = wr_en_q;
        rd_en_d    = rd_en_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        wait_cnt_d = wait_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_WRITE;
                    wr_en_d   = 1'b1;
                    wr_addr_d = '0;
                    rd_addr_d = '0;
                    busy_d    = 1'b1;
                end
            end
            S_WRITE: begin
                if (wr_addr_q == LAST_ADDR) begin
                    state_d    = S_TURN;
                    wr_en_d    = 1'b0;
                    wr_addr_d  = '0;
                    wait_cnt_d = '0;
                end else begin
                    wr_addr_d = wr_addr_q + AW'(1);
                end
            end
            S_TURN: begin
                if (wait_cnt_q == 2'(TURN_CYCLES - 1)) begin
                    state_d   = S_READ;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'(1);
                end
            end
            S_READ: begin
                if (rd_addr_q == LAST_ADDR) begin
                    state_d    = S_DRAIN;
                    rd_en_d    = 1'b0;
                    rd_addr_d  = '0;
                    wait_cnt_d = '0;
                end else begin
                    rd_addr_d = rd_addr_q + AW'(1);
                end
            end
            S_DRAIN: begin
                // Hold off DONE until the last read's data has been compared.
                if (wait_cnt_q == 2'(RD_LAT - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                wr_en_d = 1'b0;
                rd_en_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        wr_data_d = wr_en_d ? DW'(pattern(32'(wr_addr_d), 32'(DATA_BASE))) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_addr_q  <= '0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_addr_q  <= rd_addr_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    ram_rd_checker #(
        .AW        (AW),
        .DW        (DW),
        .DATA_BASE (DATA_BASE),
        .RD_LAT    (RD_LAT)
    ) u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept),
        .rd_en   (rd_en_q),
        .rd_addr (rd_addr_q),
        .rd_data (ram.ram_rd_data),
        .err     (err),
        .err_cnt (err_cnt)
    );

    assign busy            = busy_q;
    assign done            = done_q;
    assign ram.ram_wr_en   = wr_en_q;
    assign ram.ram_wr_we   = wr_en_q;
    assign ram.ram_wr_addr = wr_addr_q;
    assign ram.ram_wr_data = wr_data_q;
    assign ram.ram_rd_en   = rd_en_q;
    assign ram.ram_rd_addr = rd_addr_q;

endmodule

// File: tb/tb_ram_rw_ctrl.sv
// tb/tb_ram_rw_ctrl.sv - directed self-checking bench for ram_rw_ctrl with 1- and 2-cycle RAM models
module tb_ram_rw_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start1 = 1'b0;
    logic       start2 = 1'b0;
    logic       corrupt = 1'b0;
    logic       busy1, done1, err1, busy2, done2, err2;
    logic [6:0] err_cnt1, err_cnt2;

    int tests_run = 0;
    int tests_failed = 0;
    int mon_overlap = 0;
    int mon_rbw = 0;

    always #5 clk = ~clk;

    ram_rw_ctrl_if #(.AW(6), .DW(8)) bus1 ();
    ram_rw_ctrl_if #(.AW(6), .DW(8)) bus2 ();

    ram_rw_ctrl #(.AW(6), .DEPTH(64), .DW(8), .DATA_BASE('h10), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
        .err(err1), .err_cnt(err_cnt1), .ram(bus1)
    );

    ram_rw_ctrl #(.AW(6), .DEPTH(64), .DW(8), .DATA_BASE('h10), .RD_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
        .err(err2), .err_cnt(err_cnt2), .ram(bus2)
    );

    // RAM models: 1-cycle read for dut, 2-cycle read for dut2.
    logic [7:0] mem1 [64];
    logic [7:0] mem2 [64];
    logic [7:0] rd1_q, rd2_a, rd2_b;

    always @(posedge clk) begin
        if (bus1.ram_wr_en && bus1.ram_wr_we) mem1[bus1.ram_wr_addr] <= bus1.ram_wr_data;
        if (bus1.ram_rd_en)
            rd1_q <= mem1[bus1.ram_rd_addr] ^ {7'b0, corrupt && (bus1.ram_rd_addr == 6'd5 || bus1.ram_rd_addr == 6'd40)};
        if (bus2.ram_wr_en && bus2.ram_wr_we) mem2[bus2.ram_wr_addr] <= bus2.ram_wr_data;
        if (bus2.ram_rd_en) rd2_a <= mem2[bus2.ram_rd_addr];
        rd2_b <= rd2_a;
    end

    assign bus1.ram_rd_data = rd1_q;
    assign bus2.ram_rd_data = rd2_b;

    logic [63:0] written1;
    always @(negedge clk) begin
        if (bus1.ram_wr_en && bus1.ram_rd_en) mon_overlap++;
        if (bus2.ram_wr_en && bus2.ram_rd_en) mon_overlap++;
        if (!rst_n || !busy1) begin
            written1 = '0;
        end else begin
            if (bus1.ram_wr_en) written1[bus1.ram_wr_addr] = 1'b1;
            if (bus1.ram_rd_en && !written1[bus1.ram_rd_addr]) mon_rbw++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Observation record of the most recent run1 call.
    int r_wr_cnt, r_wr_bad, r_first_wr, r_rd_cnt, r_rd_bad, r_first_rd, r_done_cyc, r_ndone;
    logic r_err, r_busy, r_busy_after, r_done_after;
    logic [6:0] r_cnt;

    // Starts dut from IDLE; cycle 0 ends at the accepting edge. Extra start pulses at stray_a/stray_b.
    task automatic run1(input int stray_a, input int stray_b);
        r_wr_cnt = 0; r_wr_bad = 0; r_first_wr = -1; r_rd_cnt = 0; r_rd_bad = 0;
        r_first_rd = -1; r_done_cyc = -1; r_ndone = 0;
        r_err = 1'bx; r_cnt = 'x; r_busy = 1'bx;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            start1 = (cyc == stray_a || cyc == stray_b);
            if (bus1.ram_wr_en) begin
                if (r_first_wr < 0) r_first_wr = cyc;
                if (bus1.ram_wr_addr !== 6'(r_wr_cnt) || bus1.ram_wr_data !== 8'(r_wr_cnt + 16) || bus1.ram_wr_we !== 1'b1)
                    r_wr_bad++;
                r_wr_cnt++;
            end
            if (bus1.ram_rd_en) begin
                if (r_first_rd < 0) r_first_rd = cyc;
                if (bus1.ram_rd_addr !== 6'(r_rd_cnt)) r_rd_bad++;
                r_rd_cnt++;
            end
            if (done1) begin
                r_ndone++;
                r_done_cyc = cyc;
                r_err = err1;
                r_cnt = err_cnt1;
                r_busy = busy1;
                break;
            end
        end
        start1 = 1'b0;
        @(negedge clk);
        r_busy_after = busy1;
        r_done_after = done1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({busy1, done1, err1, err_cnt1} !== 10'h0) begin
            tests_failed++;
            $display("FAIL reset_status: got busy=%b done=%b err=%b cnt=%0d, expected all 0", busy1, done1, err1, err_cnt1);
        end
        tests_run++;
        if ({bus1.ram_wr_en, bus1.ram_wr_we, bus1.ram_wr_addr, bus1.ram_wr_data, bus1.ram_rd_en, bus1.ram_rd_addr} !== 23'h0) begin
            tests_failed++;
            $display("FAIL reset_ram_bus: got wr_en=%b addr=%h data=%h rd_en=%b rd_addr=%h, expected all 0",
                     bus1.ram_wr_en, bus1.ram_wr_addr, bus1.ram_wr_data, bus1.ram_rd_en, bus1.ram_rd_addr);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_clean_run();
        run1(-1, -1);
        tests_run++;
        if (r_wr_cnt !== 64 || r_wr_bad !== 0 || r_first_wr !== 1) begin
            tests_failed++;
            $display("FAIL clean_writes: got count=%0d bad=%0d first=%0d, expected 64 0 1", r_wr_cnt, r_wr_bad, r_first_wr);
        end
        tests_run++;
        if (r_rd_cnt !== 64 || r_rd_bad !== 0 || r_first_rd !== 66) begin
            tests_failed++;
            $display("FAIL clean_reads: got count=%0d bad=%0d first=%0d, expected 64 0 66", r_rd_cnt, r_rd_bad, r_first_rd);
        end
        tests_run++;
        if (r_done_cyc !== 131 || r_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL clean_done_cycle: got cycle=%0d busy=%b, expected 131 1", r_done_cyc, r_busy);
        end
        tests_run++;
        if (r_err !== 1'b0 || r_cnt !== 7'd0) begin
            tests_failed++;
            $display("FAIL clean_errors: got err=%b cnt=%0d, expected 0 0", r_err, r_cnt);
        end
        tests_run++;
        if (r_busy_after !== 1'b0 || r_done_after !== 1'b0) begin
            tests_failed++;
            $display("FAIL clean_after_done: got busy=%b done=%b, expected 0 0", r_busy_after, r_done_after);
        end
    endtask

    task automatic test_corrupt();
        corrupt = 1'b1;
        run1(-1, -1);
        corrupt = 1'b0;
        tests_run++;
        if (r_err !== 1'b1 || r_cnt !== 7'd2 || r_done_cyc !== 131) begin
            tests_failed++;
            $display("FAIL corrupt_errors: got err=%b cnt=%0d done=%0d, expected 1 2 131", r_err, r_cnt, r_done_cyc);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (err1 !== 1'b1 || err_cnt1 !== 7'd2) begin
            tests_failed++;
            $display("FAIL corrupt_hold_idle: got err=%b cnt=%0d, expected 1 2", err1, err_cnt1);
        end
        run1(-1, -1);
        tests_run++;
        if (r_err !== 1'b0 || r_cnt !== 7'd0) begin
            tests_failed++;
            $display("FAIL corrupt_cleared: got err=%b cnt=%0d, expected 0 0", r_err, r_cnt);
        end
    endtask

    task automatic test_rd_lat2();
        int first_rd = -1, last_rd = -1, done_cyc = -1;
        logic e = 1'bx;
        logic [6:0] c = 'x;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (bus2.ram_rd_en) begin
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
            end
            if (done2) begin
                done_cyc = cyc; e = err2; c = err_cnt2;
                break;
            end
        end
        tests_run++;
        if (first_rd !== 66 || last_rd !== 129 || done_cyc !== 132) begin
            tests_failed++;
            $display("FAIL lat2_timing: got first_rd=%0d last_rd=%0d done=%0d, expected 66 129 132", first_rd, last_rd, done_cyc);
        end
        tests_run++;
        if (e !== 1'b0 || c !== 7'd0) begin
            tests_failed++;
            $display("FAIL lat2_errors: got err=%b cnt=%0d, expected 0 0", e, c);
        end
    endtask

    task automatic test_stray_start();
        corrupt = 1'b1;
        run1(10, 80);
        corrupt = 1'b0;
        tests_run++;
        if (r_ndone !== 1 || r_done_cyc !== 131 || r_cnt !== 7'd2 || r_wr_bad !== 0 || r_rd_bad !== 0) begin
            tests_failed++;
            $display("FAIL stray_start_run: got done=%0d@%0d cnt=%0d wr_bad=%0d rd_bad=%0d, expected 1@131 2 0 0",
                     r_ndone, r_done_cyc, r_cnt, r_wr_bad, r_rd_bad);
        end
        repeat (4) @(negedge clk);
        tests_run++;
        if (busy1 !== 1'b0 || done1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL stray_start_idle: got busy=%b done=%b, expected 0 0", busy1, done1);
        end
    endtask

    task automatic test_back_to_back();
        int d0 = -1, d1 = -1, ndone = 0, second_wr = -1;
        logic busy_gap = 1'bx;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            if (cyc == 132) busy_gap = busy1;
            if (d0 >= 0 && second_wr < 0 && bus1.ram_wr_en) second_wr = cyc;
            if (done1) begin
                ndone++;
                if (d0 < 0) d0 = cyc;
                else begin
                    d1 = cyc;
                    start1 = 1'b0;
                    break;
                end
            end
        end
        start1 = 1'b0;
        tests_run++;
        if (d0 !== 131 || d1 !== 263 || ndone !== 2) begin
            tests_failed++;
            $display("FAIL back_to_back_done: got %0d pulses at %0d and %0d, expected 2 at 131 and 263", ndone, d0, d1);
        end
        tests_run++;
        if (busy_gap !== 1'b0 || second_wr !== 133) begin
            tests_failed++;
            $display("FAIL back_to_back_gap: got busy@132=%b second_wr=%0d, expected 0 133", busy_gap, second_wr);
        end
        repeat (4) @(negedge clk);
        tests_run++;
        if (busy1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL back_to_back_stop: got busy=%b, expected 0", busy1);
        end
    endtask

    task automatic test_reset_mid_run();
        logic       rd_en_s = 1'b0;
        logic [5:0] rd_addr_s = '0;
        int         stray_done = 0;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 86; cyc++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (done1) stray_done++;
            rd_en_s = bus1.ram_rd_en;
            rd_addr_s = bus1.ram_rd_addr;
        end
        tests_run++;
        if (rd_en_s !== 1'b1 || rd_addr_s !== 6'd20) begin
            tests_failed++;
            $display("FAIL midrun_position: got rd_en=%b rd_addr=%0d, expected 1 20", rd_en_s, rd_addr_s);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy1, done1, err1, err_cnt1, bus1.ram_wr_en, bus1.ram_wr_we, bus1.ram_wr_addr, bus1.ram_wr_data,
             bus1.ram_rd_en, bus1.ram_rd_addr} !== 33'h0) begin
            tests_failed++;
            $display("FAIL midrun_async_reset: got busy=%b done=%b err=%b cnt=%0d wr_en=%b rd_en=%b rd_addr=%0d, expected all 0",
                     busy1, done1, err1, err_cnt1, bus1.ram_wr_en, bus1.ram_rd_en, bus1.ram_rd_addr);
        end
        repeat (5) begin
            @(negedge clk);
            if (done1 || busy1) stray_done++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done1 || busy1) stray_done++;
        end
        tests_run++;
        if (stray_done !== 0) begin
            tests_failed++;
            $display("FAIL midrun_no_done: got %0d cycles with done/busy, expected 0", stray_done);
        end
        run1(-1, -1);
        tests_run++;
        if (r_done_cyc !== 131 || r_err !== 1'b0 || r_cnt !== 7'd0 || r_wr_bad !== 0 || r_rd_bad !== 0) begin
            tests_failed++;
            $display("FAIL midrun_recovery: got done=%0d err=%b cnt=%0d wr_bad=%0d rd_bad=%0d, expected 131 0 0 0 0",
                     r_done_cyc, r_err, r_cnt, r_wr_bad, r_rd_bad);
        end
    endtask

    task automatic test_protocol();
        tests_run++;
        if (mon_overlap !== 0) begin
            tests_failed++;
            $display("FAIL protocol_port_overlap: got %0d cycles, expected 0", mon_overlap);
        end
        tests_run++;
        if (mon_rbw !== 0) begin
            tests_failed++;
            $display("FAIL protocol_read_before_write: got %0d reads, expected 0", mon_rbw);
        end
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_corrupt();
        test_rd_lat2();
        test_stray_start();
        test_back_to_back();
        test_reset_mid_run();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ram_rw_ctrl.md
Name: ram_rw_ctrl

Overview:
Sequencer for the 2-port RAM self-test path. On a start pulse it fills port A with a deterministic pattern across all addresses. It then sweeps port B reads over the same addresses and compares the returned data against the expected pattern. It reports busy, done, a sticky error flag and a mismatch count, and it replaces the free-running read-address generator in the RAM test top level.

Parameters:
AW, 6, address width
DEPTH, 64, number of words exercised (addresses 0..DEPTH-1, DEPTH <= 2**AW)
DW, 8, data width
DATA_BASE, 8'h10, pattern offset: word written at addr = (addr + DATA_BASE) mod 2**DW
RD_LAT, 1, port-B read latency in clk cycles (1 or 2)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
start  in  1  single-cycle start request
busy  out  1  high from accept of start until the DONE state exits
done  out  1  one-cycle pulse at end of test
err  out  1  sticky: any mismatch since last start
err_cnt  out  AW+1  number of mismatching words in last run
ram_wr_en  out  1  port-A enable
ram_wr_we  out  1  port-A write enable
ram_wr_addr  out  AW  port-A address
ram_wr_data  out  DW  port-A write data
ram_rd_en  out  1  port-B enable
ram_rd_addr  out  AW  port-B address
ram_rd_data  in  DW  port-B read data, valid RD_LAT cycles after ram_rd_en

Behaviour:
- Clock is clk; reset is rst_n, asynchronous, active-low.
- Reset state:
  - FSM in IDLE.
  - All outputs 0: busy, done, err, err_cnt, all RAM enables, addresses and write data.
  - Check pipeline cleared.
- FSM states: IDLE, WRITE, TURN, READ, DRAIN, DONE.
- IDLE:
  - start=1 at a clock edge -> WRITE.
  - On accept, clear err, err_cnt and both address counters.
  - start is ignored in all other states.
- WRITE:
  - ram_wr_en=ram_wr_we=1; ram_wr_addr increments by 1 per cycle from 0.
  - ram_wr_data = ram_wr_addr + DATA_BASE, truncated to DW.
  - After the cycle with addr=DEPTH-1 -> TURN; ram_wr_addr returns to 0 and no wrap is visible.
- TURN:
  - One idle cycle; all enables 0.
  - Guarantees the last write has committed before the first read.
  - -> READ.
- READ:
  - ram_rd_en=1; ram_rd_addr increments by 1 per cycle from 0.
  - After addr=DEPTH-1 -> DRAIN; ram_rd_addr returns to 0.
- Check pipeline:
  - A valid bit plus expected data (addr + DATA_BASE) is delayed RD_LAT cycles alongside each read.
  - When the delayed valid bit is 1 and ram_rd_data != expected: err<=1, err_cnt<=err_cnt+1.
  - err_cnt never exceeds DEPTH, so no saturation is needed.
- DRAIN:
  - Stays RD_LAT cycles so all outstanding reads are compared.
  - -> DONE.
- DONE:
  - done=1 for exactly one cycle; busy is still 1.
  - -> IDLE, where busy=0.
  - err and err_cnt hold their values until the next accepted start.
- busy is 1 in WRITE, TURN, READ, DRAIN and DONE.
- Ports A and B are never enabled in the same cycle.
- Latency: with start accepted at edge 0, the DONE cycle is cycle DEPTH+1+DEPTH+RD_LAT+1. For the defaults this is cycle 131.
- Reset asserted mid-run: everything returns to the reset state immediately (asynchronously). No done pulse is produced. The partial RAM contents are don't-care.
- start held high across DONE->IDLE: re-accepted on the first IDLE cycle, giving back-to-back runs.

Decomposition:
- Package ram_rw_pkg holds:
  - the state enum (6 states, 3-bit encoding);
  - the TURN_CYCLES=1 constant;
  - a pattern function: addr, DATA_BASE -> expected data.
- One sub-module, ram_rd_checker, holds the RD_LAT-deep valid/expected delay line, the comparator, err and err_cnt.
- The FSM and address counters stay in ram_rw_ctrl.

Test Plan:
1. Defaults with an ideal 1-cycle RAM model, start pulse at cycle 0:
   - writes addr 0 data 0x10 through addr 63 data 0x4F;
   - reads issue from cycle 66;
   - done pulse in cycle 131;
   - err=0, err_cnt=0.
2. RAM model corrupts reads at addr 5 and 40 (bit0 flipped) -> err=1 and err_cnt=2 at done; the next clean run clears them to 0.
3. RD_LAT=2 with a 2-cycle RAM model -> DRAIN lasts 2 cycles; done in cycle 132; zero errors (checks expected-data alignment).
4. start pulses during WRITE and READ -> ignored, single done pulse, err_cnt unchanged. start held high continuously -> two consecutive runs, done pulses 132 cycles apart.
5. rst_n asserted in the READ cycle with addr 20:
   - all outputs are 0 immediately, with no done pulse;
   - after release, a new start completes a normal run with zero errors.
6. Protocol monitor for the whole test: ram_wr_en and ram_rd_en never high together; no port-B read of an address before its port-A write.
